motor_current_guard: RTL and testbench
======================================

MOTOR_CURRENT_GUARD -- requirements
Module: motor_current_guard

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of motor current-sense channels (1..8).
REQ-002 SHALL have parameter CONFIRM_CYCLES, default 524256, meaning clock cycles from first overage to the confirming re-sample (min 2).
REQ-003 SHALL have parameter RETRY_CYCLES, default 1048576, meaning the cooldown length before an automatic retry (min 2).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, meaning automatic retries allowed before lockout (0..15).
REQ-005 SHALL have parameter GLOBAL_STOP, default 1; 1 means any tripped channel stops all channels, 0 means per-channel stop.
REQ-006 SHALL have port clock, input, 1, the single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port sens, input, NUM_CH, raw asynchronous overcurrent comparator outputs, 1 = overage.
REQ-009 SHALL have port end_reset, input, 1, synchronous operator clear of trips, lockouts and retry counts.
REQ-010 SHALL have port auto_retry_en, input, 1, enabling automatic cooldown/retry.
REQ-011 SHALL have port stop, output, NUM_CH, per-channel motor stop, 1 = motor disabled.
REQ-012 SHALL have port fault_ch, output, NUM_CH, sticky record of channels tripped since the last clear.
REQ-013 SHALL have port locked, output, NUM_CH, channel in lockout.
REQ-014 SHALL have port LED_reset, output, 1, equal to the OR of stop.

Function
REQ-015 SHALL pass each sens bit through a 2-flop synchronizer; sens_s denotes the synchronized value.
REQ-016 SHALL run one independent FSM per channel with states IDLE, CONFIRM, TRIPPED, COOLDOWN, LOCKED, each with its own counter and a 4-bit retry count.
REQ-017 IDLE: sens_s=1 -> CONFIRM with counter=0.
REQ-018 CONFIRM: counter increments each cycle; sens_s going low SHALL NOT abort; at counter==CONFIRM_CYCLES-1, sens_s=1 -> TRIPPED and sets fault_ch bit, sens_s=0 -> IDLE.
REQ-019 TRIPPED: end_reset -> IDLE; else if auto_retry_en and retry count<MAX_RETRIES -> COOLDOWN with counter=0; else if retry count==MAX_RETRIES -> LOCKED; otherwise hold.
REQ-020 COOLDOWN: counter increments; at RETRY_CYCLES-1 -> IDLE and retry count +1; end_reset -> IDLE.
REQ-021 LOCKED: hold until end_reset -> IDLE; locked bit=1 only in this state.
REQ-022 Raw channel stop SHALL be 1 in TRIPPED, COOLDOWN, LOCKED; 0 in IDLE and CONFIRM.
REQ-023 GLOBAL_STOP=1: every stop bit SHALL equal OR of raw stops; GLOBAL_STOP=0: stop bit = own raw stop.
REQ-024 stop, locked and LED_reset SHALL be registered and change one cycle after the state change; trip latency from sens edge to stop = 2 sync + CONFIRM_CYCLES + 1 cycles.
REQ-025 end_reset SHALL clear all retry counts and all fault_ch bits, and take every channel in TRIPPED/COOLDOWN/LOCKED to IDLE.
REQ-026 A CONFIRM completing with sens_s=1 in the same cycle as end_reset SHALL go to TRIPPED and set fault_ch (new fault wins over clear).
REQ-027 Counters SHALL be sized $clog2 of the larger cycle parameter and SHALL never wrap; the retry count saturates at MAX_RETRIES.
REQ-028 Channels SHALL not interact except through GLOBAL_STOP output merging.

Reset
REQ-029 reset_n=0 SHALL immediately force all FSMs to IDLE and clear counters, retry counts, synchronizers, stop, fault_ch, locked and LED_reset to 0.
REQ-030 A reset_n deassertion SHALL take effect at the next clock edge; an overage present at that point restarts detection from IDLE.

Verification (NUM_CH=2, CONFIRM_CYCLES=8, RETRY_CYCLES=4, MAX_RETRIES=2, GLOBAL_STOP=1)
REQ-031 sens[0] 3-cycle pulse then low -> CONFIRM expires with sens_s=0, stop=00 throughout, fault_ch=00.
REQ-032 sens[1] held high, auto_retry_en=0 -> stop=11 exactly 11 cycles after the sens edge, fault_ch=10, holds until end_reset, then stop=00 next cycle +1.
REQ-033 sens[0] held high, auto_retry_en=1 -> trip, 4-cycle cooldown, re-trip twice, then locked=01, stop=11 held; end_reset -> locked=00, fault_ch=00.
REQ-034 GLOBAL_STOP=0, sens[0] held high -> stop=01, LED_reset=1, channel 1 unaffected by sens[1]=0.
REQ-035 end_reset pulsed on the cycle CONFIRM completes with sens high -> TRIPPED, fault_ch bit set.
REQ-036 reset_n asserted mid-COOLDOWN -> all outputs 0 immediately, no clock edge required.

Source files
------------

// File: rtl/motor_current_guard.sv
// Motor overcurrent guard: per-channel confirm / trip / cooldown / lockout
// state machines fed by synchronized comparator inputs, with registered
// stop, lockout and indicator outputs.
module motor_current_guard #(
    parameter int NUM_CH         = 2,
    parameter int CONFIRM_CYCLES = 524256,
    parameter int RETRY_CYCLES   = 1048576,
    parameter int MAX_RETRIES    = 3,
    parameter int GLOBAL_STOP    = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] sens,
    input  logic              end_reset,
    input  logic              auto_retry_en,
    output logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] fault_ch,
    output logic [NUM_CH-1:0] locked,
    output logic              LED_reset
);

    // Counter is sized for the longer of the two timed phases; neither phase
    // ever counts past its own terminal value, so it never wraps.
    localparam int MAX_CYC = (CONFIRM_CYCLES > RETRY_CYCLES) ? CONFIRM_CYCLES : RETRY_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] CONF_LAST  = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONFIRM  = 3'd1,
        ST_TRIPPED  = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_LOCKED   = 3'd4
    } state_t;

    logic [NUM_CH-1:0] sens_meta_r;
    logic [NUM_CH-1:0] sens_sync_r;   // synchronized comparator value (sens_s)
    logic [NUM_CH-1:0] raw_stop_s;
    logic [NUM_CH-1:0] lock_s;
    logic [NUM_CH-1:0] fault_s;
    logic [NUM_CH-1:0] stop_next_s;
    logic [NUM_CH-1:0] stop_r;
    logic [NUM_CH-1:0] locked_r;
    logic              led_r;

    // Two-flop synchronizer for the asynchronous comparator outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sens_meta_r <= '0;
            sens_sync_r <= '0;
        end else begin
            sens_meta_r <= sens;
            sens_sync_r <= sens_meta_r;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           state_r;
        logic [CNT_W-1:0] cnt_r;
        logic [3:0]       retry_r;
        logic             fault_r;

        // Per-channel guard FSM; a confirmed trip sets the fault bit even when
        // the operator clear lands on the same cycle.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state_r <= ST_IDLE;
                cnt_r   <= '0;
                retry_r <= 4'd0;
                fault_r <= 1'b0;
            end else begin
                if (end_reset) begin
                    retry_r <= 4'd0;
                    fault_r <= 1'b0;
                end
                case (state_r)
                    ST_IDLE: begin
                        if (sens_sync_r[g]) begin
                            state_r <= ST_CONFIRM;
                            cnt_r   <= '0;
                        end
                    end
                    ST_CONFIRM: begin
                        if (cnt_r == CONF_LAST) begin
                            if (sens_sync_r[g]) begin
                                state_r <= ST_TRIPPED;
                                fault_r <= 1'b1;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ST_TRIPPED: begin
                        if (end_reset) begin
                            state_r <= ST_IDLE;
                        end else if (auto_retry_en && (retry_r < RETRY_MAX)) begin
                            state_r <= ST_COOLDOWN;
                            cnt_r   <= '0;
                        end else if (retry_r == RETRY_MAX) begin
                            state_r <= ST_LOCKED;
                        end
                    end
                    ST_COOLDOWN: begin
                        if (end_reset) begin
                            state_r <= ST_IDLE;
                        end else if (cnt_r == RETRY_LAST) begin
                            state_r <= ST_IDLE;
                            if (retry_r < RETRY_MAX) begin
                                retry_r <= retry_r + 4'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ST_LOCKED: begin
                        if (end_reset) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end

        assign raw_stop_s[g] = (state_r == ST_TRIPPED) || (state_r == ST_COOLDOWN) ||
                               (state_r == ST_LOCKED);
        assign lock_s[g]     = (state_r == ST_LOCKED);
        assign fault_s[g]    = fault_r;
    end

    // Merge raw channel stops: all channels stop together or each stops alone.
    always_comb begin
        stop_next_s = raw_stop_s;
        if (GLOBAL_STOP != 0) begin
            stop_next_s = {NUM_CH{|raw_stop_s}};
        end else begin
            stop_next_s = raw_stop_s;
        end
    end

    // Output registers, one cycle behind the channel state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stop_r   <= '0;
            locked_r <= '0;
            led_r    <= 1'b0;
        end else begin
            stop_r   <= stop_next_s;
            locked_r <= lock_s;
            led_r    <= |raw_stop_s;
        end
    end

    assign stop      = stop_r;
    assign locked    = locked_r;
    assign LED_reset = led_r;
    assign fault_ch  = fault_s;

endmodule

// File: tb/tb_motor_current_guard.sv
// Bench for motor_current_guard: a global-stop and a per-channel-stop instance
// share stimulus; hand vectors, timed corner sequences and random stimulus are
// checked against an independent cycle model of the guard rules.
module tb_motor_current_guard;

    localparam int NC = 2;
    localparam int CC = 8;
    localparam int RC = 4;
    localparam int MR = 2;

    logic          clock;
    logic          reset_n;
    logic [NC-1:0] sens;
    logic          end_reset;
    logic          auto_retry_en;
    logic [NC-1:0] stop_g, fault_g, locked_g;
    logic [NC-1:0] stop_p, fault_p, locked_p;
    logic          led_g, led_p;

    motor_current_guard #(.NUM_CH(NC), .CONFIRM_CYCLES(CC), .RETRY_CYCLES(RC),
                          .MAX_RETRIES(MR), .GLOBAL_STOP(1)) dut_g (
        .clock(clock), .reset_n(reset_n), .sens(sens), .end_reset(end_reset),
        .auto_retry_en(auto_retry_en), .stop(stop_g), .fault_ch(fault_g),
        .locked(locked_g), .LED_reset(led_g));

    motor_current_guard #(.NUM_CH(NC), .CONFIRM_CYCLES(CC), .RETRY_CYCLES(RC),
                          .MAX_RETRIES(MR), .GLOBAL_STOP(0)) dut_p (
        .clock(clock), .reset_n(reset_n), .sens(sens), .end_reset(end_reset),
        .auto_retry_en(auto_retry_en), .stop(stop_p), .fault_ch(fault_p),
        .locked(locked_p), .LED_reset(led_p));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: delay line for the synchronizer, countdown timers for
    // the confirm and cooldown windows, and flags for the stopped conditions.
    bit m_sq1[NC], m_sq2[NC];
    bit m_conf[NC], m_trip[NC], m_cool[NC], m_lock[NC], m_fault[NC];
    int m_conf_left[NC], m_cool_left[NC], m_retries[NC];
    logic [NC-1:0] e_raw, e_lock;

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_sq1[c] = 0; m_sq2[c] = 0; m_conf[c] = 0; m_trip[c] = 0;
            m_cool[c] = 0; m_lock[c] = 0; m_fault[c] = 0;
            m_conf_left[c] = 0; m_cool_left[c] = 0; m_retries[c] = 0;
        end
        e_raw = '0;
        e_lock = '0;
    endtask

    task automatic model_step();
        logic [NC-1:0] raw_now, lock_now;
        for (int c = 0; c < NC; c++) begin
            raw_now[c]  = m_trip[c] | m_cool[c] | m_lock[c];
            lock_now[c] = m_lock[c];
        end
        for (int c = 0; c < NC; c++) begin
            bit s;
            bit newf;
            s = m_sq2[c];
            newf = 0;
            if (m_conf[c]) begin
                if (m_conf_left[c] == 1) begin
                    m_conf[c] = 0;
                    if (s) begin m_trip[c] = 1; newf = 1; end
                end else m_conf_left[c]--;
            end else if (m_trip[c]) begin
                if (end_reset) m_trip[c] = 0;
                else if (auto_retry_en && m_retries[c] < MR) begin
                    m_trip[c] = 0; m_cool[c] = 1; m_cool_left[c] = RC;
                end else if (m_retries[c] == MR) begin
                    m_trip[c] = 0; m_lock[c] = 1;
                end
            end else if (m_cool[c]) begin
                if (end_reset) m_cool[c] = 0;
                else if (m_cool_left[c] == 1) begin
                    m_cool[c] = 0;
                    m_retries[c] = (m_retries[c] < MR) ? m_retries[c] + 1 : MR;
                end else m_cool_left[c]--;
            end else if (m_lock[c]) begin
                if (end_reset) m_lock[c] = 0;
            end else if (s) begin
                m_conf[c] = 1; m_conf_left[c] = CC;
            end
            if (end_reset) m_retries[c] = 0;
            m_fault[c] = (end_reset ? 1'b0 : m_fault[c]) | newf;
            m_sq2[c] = m_sq1[c];
            m_sq1[c] = sens[c];
        end
        e_raw  = raw_now;
        e_lock = lock_now;
    endtask

    task automatic compare_model();
        logic [NC-1:0] mf;
        for (int c = 0; c < NC; c++) mf[c] = m_fault[c];
        chk("model_stop_global", 8'(stop_g), 8'({NC{|e_raw}}));
        chk("model_stop_perch", 8'(stop_p), 8'(e_raw));
        chk("model_fault_global", 8'(fault_g), 8'(mf));
        chk("model_fault_perch", 8'(fault_p), 8'(mf));
        chk("model_locked_global", 8'(locked_g), 8'(e_lock));
        chk("model_locked_perch", 8'(locked_p), 8'(e_lock));
        chk("model_led_global", 8'(led_g), 8'(|e_raw));
        chk("model_led_perch", 8'(led_p), 8'(|e_raw));
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        compare_model();
    endtask

    typedef struct {
        logic [1:0] sens;
        logic       er;
        logic       ar;
        int         n;
        logic [1:0] stop_g;
        logic [1:0] stop_p;
        logic [1:0] fault;
        logic [1:0] locked;
    } vec_t;

    vec_t tbl [27];
    int   cnt;

    initial begin
        // short pulse: confirm window expires low
        tbl[0]  = '{2'b01, 1'b0, 1'b0, 3,  2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{2'b00, 1'b0, 1'b0, 20, 2'b00, 2'b00, 2'b00, 2'b00};
        // channel 1 held, no retry: trip, hold, operator clear
        tbl[2]  = '{2'b10, 1'b0, 1'b0, 10, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{2'b10, 1'b0, 1'b0, 1,  2'b00, 2'b00, 2'b10, 2'b00};
        tbl[4]  = '{2'b10, 1'b0, 1'b0, 1,  2'b11, 2'b10, 2'b10, 2'b00};
        tbl[5]  = '{2'b10, 1'b0, 1'b0, 30, 2'b11, 2'b10, 2'b10, 2'b00};
        tbl[6]  = '{2'b00, 1'b1, 1'b0, 1,  2'b11, 2'b10, 2'b00, 2'b00};
        tbl[7]  = '{2'b00, 1'b0, 1'b0, 1,  2'b00, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{2'b00, 1'b0, 1'b0, 15, 2'b00, 2'b00, 2'b00, 2'b00};
        // channel 0 held with retry: two cooldowns then lockout
        tbl[9]  = '{2'b01, 1'b0, 1'b1, 11, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[10] = '{2'b01, 1'b0, 1'b1, 1,  2'b11, 2'b01, 2'b01, 2'b00};
        tbl[11] = '{2'b01, 1'b0, 1'b1, 4,  2'b11, 2'b01, 2'b01, 2'b00};
        tbl[12] = '{2'b01, 1'b0, 1'b1, 1,  2'b00, 2'b00, 2'b01, 2'b00};
        tbl[13] = '{2'b01, 1'b0, 1'b1, 9,  2'b11, 2'b01, 2'b01, 2'b00};
        tbl[14] = '{2'b01, 1'b0, 1'b1, 5,  2'b00, 2'b00, 2'b01, 2'b00};
        tbl[15] = '{2'b01, 1'b0, 1'b1, 9,  2'b11, 2'b01, 2'b01, 2'b00};
        tbl[16] = '{2'b01, 1'b0, 1'b1, 1,  2'b11, 2'b01, 2'b01, 2'b01};
        tbl[17] = '{2'b01, 1'b0, 1'b1, 20, 2'b11, 2'b01, 2'b01, 2'b01};
        tbl[18] = '{2'b00, 1'b1, 1'b1, 1,  2'b11, 2'b01, 2'b00, 2'b01};
        tbl[19] = '{2'b00, 1'b0, 1'b1, 1,  2'b00, 2'b00, 2'b00, 2'b00};
        tbl[20] = '{2'b00, 1'b0, 1'b1, 15, 2'b00, 2'b00, 2'b00, 2'b00};
        // operator clear on the very cycle a confirm completes high
        tbl[21] = '{2'b10, 1'b0, 1'b0, 10, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[22] = '{2'b10, 1'b1, 1'b0, 1,  2'b00, 2'b00, 2'b10, 2'b00};
        tbl[23] = '{2'b10, 1'b0, 1'b0, 1,  2'b11, 2'b10, 2'b10, 2'b00};
        tbl[24] = '{2'b10, 1'b0, 1'b0, 5,  2'b11, 2'b10, 2'b10, 2'b00};
        tbl[25] = '{2'b00, 1'b1, 1'b0, 1,  2'b11, 2'b10, 2'b00, 2'b00};
        tbl[26] = '{2'b00, 1'b0, 1'b0, 15, 2'b00, 2'b00, 2'b00, 2'b00};

        reset_n = 1'b0;
        sens = '0;
        end_reset = 1'b0;
        auto_retry_en = 1'b0;
        model_reset();
        #1;
        chk("reset_stop", 8'({stop_g, stop_p}), 8'h00);
        chk("reset_fault", 8'({fault_g, fault_p}), 8'h00);
        chk("reset_locked_led", 8'({locked_g, locked_p, led_g, led_p}), 8'h00);
        repeat (2) tick();
        reset_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 27; i++) begin
            sens = tbl[i].sens;
            end_reset = tbl[i].er;
            auto_retry_en = tbl[i].ar;
            repeat (tbl[i].n) tick();
            chk($sformatf("vec%0d_stop_global", i), 8'(stop_g), 8'(tbl[i].stop_g));
            chk($sformatf("vec%0d_stop_perch", i), 8'(stop_p), 8'(tbl[i].stop_p));
            chk($sformatf("vec%0d_fault", i), 8'(fault_g), 8'(tbl[i].fault));
            chk($sformatf("vec%0d_locked", i), 8'(locked_g), 8'(tbl[i].locked));
            chk($sformatf("vec%0d_led_global", i), 8'(led_g), 8'(|tbl[i].stop_g));
            chk($sformatf("vec%0d_led_perch", i), 8'(led_p), 8'(|tbl[i].stop_p));
        end
        end_reset = 1'b0;

        // trip latency, counted from the edge that first samples sens
        sens = 2'b10;
        auto_retry_en = 1'b0;
        cnt = 0;
        while (stop_g == 2'b00 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("trip_latency", 8'(cnt - 1), 8'(2 + CC + 1));
        sens = 2'b00;
        end_reset = 1'b1;
        tick();
        end_reset = 1'b0;
        repeat (15) tick();

        // asynchronous reset in the middle of a cooldown
        sens = 2'b01;
        auto_retry_en = 1'b1;
        repeat (14) tick();
        chk("cooldown_active", 8'(stop_g), 8'h03);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_stop", 8'({stop_g, stop_p}), 8'h00);
        chk("async_reset_fault", 8'({fault_g, fault_p}), 8'h00);
        chk("async_reset_locked_led", 8'({locked_g, locked_p, led_g, led_p}), 8'h00);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (11) tick();
        chk("restart_no_early_stop", 8'(stop_g), 8'h00);
        chk("restart_fault", 8'(fault_g), 8'h01);
        tick();
        chk("restart_trip", 8'(stop_g), 8'h03);
        sens = 2'b00;
        end_reset = 1'b1;
        tick();
        end_reset = 1'b0;
        auto_retry_en = 1'b0;
        repeat (15) tick();

        // randomized segments against the model
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            sens = 2'($urandom_range(0, 3));
            auto_retry_en = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            for (int k = 0; k < len; k++) begin
                end_reset = ($urandom_range(0, 39) == 0);
                tick();
            end
        end
        end_reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
